// File: rtl/arc4_pkg.sv
// arc4_pkg: state encoding and default sizing shared by the ARC4 key-schedule logic.
package arc4_pkg;

    typedef enum logic [2:0] {IDLE, INIT, RD_I, RD_J, WR_J, WR_I} ksa_state_t;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_KEY_BYTES = 3;

endpackage

// File: rtl/ksa_param.sv
// ksa_param: ARC4 key-scheduling engine that permutes an external S-memory
// (one-cycle read latency) using a KEY_BYTES-long key.
module ksa_param
    import arc4_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int KEY_BYTES = DEF_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic                   init_first,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [ADDR_W-1:0]      addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W:0]   LAST_I = (ADDR_W+1)'((1 << ADDR_W) - 1);
    localparam logic [KI_W-1:0]   LAST_K = KI_W'(KEY_BYTES - 1);

    ksa_state_t        r_state;
    logic [ADDR_W:0]   r_i;
    logic [ADDR_W-1:0] r_j;
    logic [KI_W-1:0]   r_kidx;
    logic [7:0]        r_key [KEY_BYTES];
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [ADDR_W-1:0] w_jn;

    // Read data arrives in RD_J, so the j address must be formed combinationally from it.
    assign w_jn = r_j + rddata[ADDR_W-1:0] + r_key[r_kidx][ADDR_W-1:0];

    always_comb begin
        rdy    = (r_state == IDLE);
        wren   = (r_state == INIT) || (r_state == WR_J) || (r_state == WR_I);
        addr   = (r_state == RD_J) ? w_jn :
                 (r_state == WR_J) ? r_j :
                 (r_state == IDLE) ? '0 : r_i[ADDR_W-1:0];
        wrdata = (r_state == INIT) ? 8'(r_i) :
                 (r_state == WR_J) ? r_si :
                 (r_state == WR_I) ? r_sj : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            for (int k = 0; k < KEY_BYTES; k++) r_key[k] <= '0;
        end else begin
            case (r_state)
                IDLE: if (en) begin
                    for (int k = 0; k < KEY_BYTES; k++) r_key[k] <= key[8*(KEY_BYTES-1-k) +: 8];
                    r_i     <= '0;
                    r_j     <= '0;
                    r_kidx  <= '0;
                    r_state <= init_first ? INIT : RD_I;
                end
                INIT: begin
                    r_i     <= (r_i == LAST_I) ? '0 : r_i + 1'b1;
                    r_state <= (r_i == LAST_I) ? RD_I : INIT;
                end
                RD_I: r_state <= RD_J;
                RD_J: begin
                    r_si    <= rddata;
                    r_j     <= w_jn;
                    r_state <= WR_J;
                end
                WR_J: begin
                    r_sj    <= rddata;
                    r_state <= WR_I;
                end
                WR_I: if (r_i == LAST_I) begin
                    r_state <= IDLE;
                end else begin
                    r_i     <= r_i + 1'b1;
                    r_kidx  <= (r_kidx == LAST_K) ? '0 : r_kidx + 1'b1;
                    r_state <= RD_I;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ksa_param.md
KSA_PARAM -- requirements
Module: ksa_param

Interface
REQ-001 Parameter ADDR_W, default 8: S-array address width; N = 2**ADDR_W entries, legal range 2..8.
REQ-002 Parameter KEY_BYTES, default 3: key length in bytes, legal range 1..32.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 en  input  1: start request, sampled only while rdy=1.
REQ-006 rdy  output  1: high when idle and able to accept en.
REQ-007 init_first  input  1: sampled with en; 1 = fill S with identity before scheduling.
REQ-008 key  input  8*KEY_BYTES: key, byte 0 = most significant byte; sampled with en.
REQ-009 addr  output  ADDR_W: S-memory address.
REQ-010 rddata  input  8: S-memory read data, valid one cycle after addr presented with wren=0.
REQ-011 wrdata  output  8: S-memory write data.
REQ-012 wren  output  1: S-memory write enable.

Function
REQ-013 Handshake: rising edge with rdy=1 and en=1 accepts a job; rdy drops in the next cycle; en while rdy=0 is ignored.
REQ-014 Key and init_first are registered at acceptance; later changes do not affect the running job.
REQ-015 States: IDLE, INIT, RD_I, RD_J, WR_J, WR_I; IDLE -> INIT (init_first=1) or RD_I (init_first=0).
REQ-016 INIT: one write per cycle, addr=k, wrdata=k, k=0..N-1; after k=N-1 -> RD_I with i=0, j=0.
REQ-017 RD_I: addr=i, wren=0.
REQ-018 RD_J: capture si=rddata; j_next = (j + si + key[i mod KEY_BYTES]) mod N; addr=j_next, wren=0; j <= j_next.
REQ-019 WR_J: capture sj=rddata; addr=j, wrdata=si, wren=1.
REQ-020 WR_I: addr=i, wrdata=sj, wren=1; if i=N-1 -> IDLE, else i<=i+1, -> RD_I.
REQ-021 Key index: separate counter wrapping at KEY_BYTES-1; no divider or modulo operator.
REQ-022 i counter is ADDR_W+1 bits so the terminal test is unambiguous at N=256.
REQ-023 j arithmetic truncated to ADDR_W bits; rddata upper bits beyond ADDR_W ignored in j sum.
REQ-024 i=j case: both writes target the same address; final S[i] equals original S[i].
REQ-025 Latency: rdy high exactly 4N (+N if init_first) rising edges after the accepting edge.
REQ-026 wren=0 in IDLE, RD_I, RD_J; exactly one write per cycle in INIT, WR_J, WR_I.

Reset
REQ-027 rst_n low: state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, key index=0, immediately and asynchronously.
REQ-028 Reset mid-job aborts it; memory contents are left as-is; first edge after release may accept en.

Structure
REQ-029 Shared package arc4_pkg holds the state enum type and default ADDR_W/KEY_BYTES constants.
REQ-030 Single module, no sub-module; memory is external to the block.

Verification
REQ-031 ADDR_W=2, KEY_BYTES=3, key=0x010203, init_first=1 -> S=[2,0,1,3]; rdy high 20 edges after acceptance.
REQ-032 ADDR_W=2, KEY_BYTES=3, key=0x000000, init_first=1 -> S=[0,2,3,1] (covers i=j at i=0,1).
REQ-033 ADDR_W=8, key=0x00033C, init_first=1 -> S matches software ARC4 KSA model; rdy high after 1280 edges.
REQ-034 Preload S=[3,2,1,0], init_first=0, ADDR_W=2, key=0x010203 -> S matches software model; no INIT writes observed.
REQ-035 Pulse en and change key at cycle 10 of a running job -> ignored; result identical to undisturbed run.
REQ-036 Assert rst_n low mid-KSA -> rdy=1, wren=0 same cycle; fresh job afterwards produces the correct S.
